// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, supported-op bound and arbiter state type.
// Used by the alu, the arbiter and the decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic logic op_supported(logic [3:0] op);
        return op <= ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub, bitwise logic, shifts by b[4:0], signed/unsigned set-less-than.
// Unsupported op codes produce a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = WIDTH'($signed(a) >>> shamt);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero_flag = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two valid/ready requesters.
// One operation in flight; the result is held in a response register until consumed.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ID_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [3:0]          req0_op,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [3:0]          req1_op,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WIDTH-1:0]    resp_result,
    output logic                resp_zero,
    output logic [ID_WIDTH-1:0] resp_id,
    output logic                resp_err
);

    arb_state_t          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                err_q, err_d;

    logic                grant;
    logic                can_accept;
    logic                accept;
    logic                op_err;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [3:0]          alu_op;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_zero;

    // Requester 1 wins when it is the only one asking, or when both ask and the pointer favours it.
    assign grant      = req1_valid & (~req0_valid | ptr_q);
    assign can_accept = (state_q == IDLE) | resp_ready;
    assign accept     = can_accept & (req0_valid | req1_valid) & rst_n;

    assign req0_ready = can_accept & ~grant & rst_n;
    assign req1_ready = can_accept &  grant & rst_n;

    assign alu_a  = grant ? req1_a  : req0_a;
    assign alu_b  = grant ? req1_b  : req0_b;
    assign alu_op = grant ? req1_op : req0_op;
    assign op_err = ~op_supported(alu_op);

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .alu_op    (alu_op),
        .result    (alu_result),
        .zero_flag (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        zero_d   = zero_q;
        id_d     = id_q;
        err_d    = err_q;
        if (accept) begin
            state_d  = HOLD;
            ptr_d    = ~grant;
            result_d = op_err ? '0 : alu_result;
            zero_d   = op_err ? 1'b1 : alu_zero;
            id_d     = ID_WIDTH'(grant);
            err_d    = op_err;
        end else if ((state_q == HOLD) && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            id_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    assign resp_valid  = (state_q == HOLD);
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_id     = id_q;
    assign resp_err    = err_q;

endmodule
